z16_mem_arbiter: RTL and testbench
==================================

Z16_MEM_ARBITER -- requirements
Module: z16_mem_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 16, data width of all data buses.
REQ-002 SHALL have parameter: ADDR_W, 16, byte address width of all address buses.
REQ-003 SHALL have port: i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: i_cpu_req input 1, i_cpu_wen input 1, i_cpu_addr input ADDR_W, i_cpu_wdata input DATA_W  CPU load/store request.
REQ-006 SHALL have ports: o_cpu_gnt output 1, o_cpu_stall output 1, o_cpu_rvalid output 1, o_cpu_rdata output DATA_W  CPU grant, stall and read response.
REQ-007 SHALL have ports: i_dbg_req input 1, i_dbg_wen input 1, i_dbg_addr input ADDR_W, i_dbg_wdata input DATA_W, i_dbg_lock input 1  debug/program-loader request and lock.
REQ-008 SHALL have ports: o_dbg_gnt output 1, o_dbg_rvalid output 1, o_dbg_rdata output DATA_W  debug grant and read response.
REQ-009 SHALL have ports: o_mem_addr output ADDR_W, o_mem_wen output 1, o_mem_wdata output DATA_W, i_mem_rdata input DATA_W  to single-port data memory (combinational read, write on clock edge).
REQ-010 SHALL have port: o_locked output 1  high while in LOCK state.

Function
REQ-011 SHALL share one data memory between CPU and debug requesters; at most one grant per cycle.
REQ-012 SHALL produce grants combinationally in the same cycle as the request; the granted request's address/wen/wdata SHALL drive o_mem_* that cycle.
REQ-013 SHALL require requesters to hold req, wen, addr and wdata stable until their gnt is seen; a request completes on the clock edge where gnt=1.
REQ-014 SHALL, with no grant, drive o_mem_wen=0, o_mem_addr=0, o_mem_wdata=0.
REQ-015 SHALL implement states ARB and LOCK; reset state ARB.
REQ-016 In ARB: single requester is granted; on both requesting, the one not in r_last is granted; r_last updates to the granted requester at each grant edge.
REQ-017 SHALL transition ARB->LOCK at an edge where dbg is granted with i_dbg_lock=1.
REQ-018 In LOCK: only dbg may be granted; CPU gnt=0 regardless of i_cpu_req.
REQ-019 SHALL transition LOCK->ARB at the first edge where i_dbg_lock=0; CPU may be granted from the following cycle.
REQ-020 SHALL set o_cpu_stall = i_cpu_req & ~o_cpu_gnt.
REQ-021 For a granted read (wen=0), SHALL register i_mem_rdata and assert the requester's rvalid for exactly one cycle after the grant edge; rdata SHALL hold its last value otherwise.
REQ-022 Granted writes SHALL produce no rvalid.
REQ-023 Back-to-back grants to the same requester SHALL be allowed when the other is idle (full throughput, 1 access/cycle).
REQ-024 Address SHALL pass through unmodified; alignment is the requester's responsibility.

Reset
REQ-025 On i_rst_n=0, asynchronously: state=ARB, r_last=dbg (CPU wins first tie), both rvalid=0, both rdata=0, o_locked=0.
REQ-026 Reset asserted mid-access SHALL abort it: no rvalid after release; any write in that cycle is not guaranteed.
REQ-027 Grants during reset SHALL be 0 and o_mem_wen SHALL be 0.

Structure
REQ-028 State encoding (ARB, LOCK) and requester ID constants (CPU=0, DBG=1) SHALL live in the shared Z16 package.
REQ-029 Round-robin pick logic SHALL be one sub-module, z16_rr_pick2 (two requests, last-served bit in, one-hot grant out).

Verification
REQ-030 CPU read 0x0010 alone, memory returns 0xBEEF -> o_cpu_gnt same cycle, o_cpu_rvalid=1 and o_cpu_rdata=0xBEEF next cycle for one cycle.
REQ-031 First post-reset cycle both request -> CPU granted, dbg stalls; next cycle dbg granted; alternation continues while both hold requests.
REQ-032 dbg writes 0x1234 to 0x0020 with i_dbg_lock=1, CPU requesting -> LOCK entered, o_locked=1, CPU stalled for 4 dbg writes; lock dropped -> CPU granted the cycle after.
REQ-033 CPU write 0x0004 <- 0x00AA then read 0x0004 -> no rvalid on write, read returns 0x00AA.
REQ-034 Assert i_rst_n=0 in cycle of a granted dbg read -> no o_dbg_rvalid after release, state ARB, o_locked=0.
REQ-035 Idle both requesters -> o_mem_wen=0, o_mem_addr=0, no grants, no rvalid.

Source files
------------

// File: rtl/z16_mem_arbiter_pkg.sv
// Shared Z16 definitions: arbiter state encoding, requester IDs and small helpers
// used by the data-memory arbiter and its round-robin picker.
package z16_mem_arbiter_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   localparam logic REQ_ID_CPU = 1'b0;
   localparam logic REQ_ID_DBG = 1'b1;
   localparam int   N_REQ      = 2;

   // A granted access that returns data to its requester.
   function automatic logic is_read(input logic gnt, input logic wen);
      return gnt & ~wen;
   endfunction

endpackage

// File: rtl/z16_rr_pick2.sv
// Two-way round-robin picker: a lone request always wins; on a tie the
// requester that was not served last wins. Output is one-hot or zero.
module z16_rr_pick2
   import z16_mem_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic             last,
   output logic [N_REQ-1:0] gnt
);

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pick
      localparam logic MY_ID = 1'(gi);
      assign gnt[gi] = req[gi] & (~req[N_REQ-1-gi] | (last != MY_ID));
   end

endmodule

// File: rtl/z16_mem_arbiter.sv
// Arbitrates one single-port data memory between the CPU and the debug/program
// loader, with a debug lock that shuts the CPU out for multi-word transfers.
module z16_mem_arbiter
   import z16_mem_arbiter_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,

   input  logic              i_cpu_req,
   input  logic              i_cpu_wen,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_gnt,
   output logic              o_cpu_stall,
   output logic              o_cpu_rvalid,
   output logic [DATA_W-1:0] o_cpu_rdata,

   input  logic              i_dbg_req,
   input  logic              i_dbg_wen,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   input  logic [DATA_W-1:0] i_dbg_wdata,
   input  logic              i_dbg_lock,
   output logic              o_dbg_gnt,
   output logic              o_dbg_rvalid,
   output logic [DATA_W-1:0] o_dbg_rdata,

   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_wen,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,

   output logic              o_locked
);

   arb_state_e       state_reg, state_next;
   logic             last_reg, last_next;
   logic [N_REQ-1:0] req_vec;
   logic [N_REQ-1:0] gnt_vec;
   logic [N_REQ-1:0] wen_vec;
   logic             cpu_gnt, dbg_gnt;

   logic             rvalid_reg [N_REQ];
   logic [DATA_W-1:0] rdata_reg  [N_REQ];

   // Requests are masked while reset is held so no grant or write leaks out,
   // and the CPU is masked entirely while the debug port holds the lock.
   assign req_vec[REQ_ID_CPU] = i_rst_n & i_cpu_req & (state_reg == ARB);
   assign req_vec[REQ_ID_DBG] = i_rst_n & i_dbg_req;
   assign wen_vec[REQ_ID_CPU] = i_cpu_wen;
   assign wen_vec[REQ_ID_DBG] = i_dbg_wen;

   z16_rr_pick2 u_pick (
      .req  (req_vec),
      .last (last_reg),
      .gnt  (gnt_vec)
   );

   assign cpu_gnt     = gnt_vec[REQ_ID_CPU];
   assign dbg_gnt     = gnt_vec[REQ_ID_DBG];
   assign o_cpu_gnt   = cpu_gnt;
   assign o_dbg_gnt   = dbg_gnt;
   assign o_cpu_stall = i_cpu_req & ~cpu_gnt;
   assign o_locked    = (state_reg == LOCK);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= ARB;
         last_reg  <= REQ_ID_DBG;
      end else begin
         state_reg <= state_next;
         last_reg  <= last_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      last_next  = last_reg;
      if (cpu_gnt) begin
         last_next = REQ_ID_CPU;
      end else if (dbg_gnt) begin
         last_next = REQ_ID_DBG;
      end
      case (state_reg)
         ARB: begin
            if (dbg_gnt && i_dbg_lock) begin
               state_next = LOCK;
            end
         end
         LOCK: begin
            if (!i_dbg_lock) begin
               state_next = ARB;
            end
         end
         default: state_next = ARB;
      endcase
   end

   always_comb begin
      o_mem_addr  = '0;
      o_mem_wen   = 1'b0;
      o_mem_wdata = '0;
      if (cpu_gnt) begin
         o_mem_addr  = i_cpu_addr;
         o_mem_wen   = i_cpu_wen;
         o_mem_wdata = i_cpu_wdata;
      end else if (dbg_gnt) begin
         o_mem_addr  = i_dbg_addr;
         o_mem_wen   = i_dbg_wen;
         o_mem_wdata = i_dbg_wdata;
      end
   end

   // Read data is captured on the grant edge; it keeps its value until the
   // same requester's next read so software can sample it late.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_resp
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            rvalid_reg[gi] <= 1'b0;
            rdata_reg[gi]  <= '0;
         end else begin
            rvalid_reg[gi] <= is_read(gnt_vec[gi], wen_vec[gi]);
            if (is_read(gnt_vec[gi], wen_vec[gi])) begin
               rdata_reg[gi] <= i_mem_rdata;
            end
         end
      end
   end

   assign o_cpu_rvalid = rvalid_reg[REQ_ID_CPU];
   assign o_cpu_rdata  = rdata_reg[REQ_ID_CPU];
   assign o_dbg_rvalid = rvalid_reg[REQ_ID_DBG];
   assign o_dbg_rdata  = rdata_reg[REQ_ID_DBG];

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Directed bench for z16_mem_arbiter: combinational grant/mux checks inline,
// read responses checked by a scoreboard monitor against queued expectations.
module tb_z16_mem_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_cpu_req, i_cpu_wen;
   logic [15:0] i_cpu_addr, i_cpu_wdata;
   logic        o_cpu_gnt, o_cpu_stall, o_cpu_rvalid;
   logic [15:0] o_cpu_rdata;
   logic        i_dbg_req, i_dbg_wen, i_dbg_lock;
   logic [15:0] i_dbg_addr, i_dbg_wdata;
   logic        o_dbg_gnt, o_dbg_rvalid;
   logic [15:0] o_dbg_rdata;
   logic [15:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
   logic        o_mem_wen;
   logic        o_locked;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t cpu_q[$];
   exp_t dbg_q[$];
   exp_t mon_e;

   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;
   logic preload;
   logic [15:0] mem [0:255];

   z16_mem_arbiter #(.DATA_W(16), .ADDR_W(16)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_cpu_req    (i_cpu_req),
      .i_cpu_wen    (i_cpu_wen),
      .i_cpu_addr   (i_cpu_addr),
      .i_cpu_wdata  (i_cpu_wdata),
      .o_cpu_gnt    (o_cpu_gnt),
      .o_cpu_stall  (o_cpu_stall),
      .o_cpu_rvalid (o_cpu_rvalid),
      .o_cpu_rdata  (o_cpu_rdata),
      .i_dbg_req    (i_dbg_req),
      .i_dbg_wen    (i_dbg_wen),
      .i_dbg_addr   (i_dbg_addr),
      .i_dbg_wdata  (i_dbg_wdata),
      .i_dbg_lock   (i_dbg_lock),
      .o_dbg_gnt    (o_dbg_gnt),
      .o_dbg_rvalid (o_dbg_rvalid),
      .o_dbg_rdata  (o_dbg_rdata),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wen    (o_mem_wen),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rdata  (i_mem_rdata),
      .o_locked     (o_locked)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc = cyc + 1;

   // Memory model: combinational read, write on the clock edge.
   assign i_mem_rdata = mem[o_mem_addr[7:0]];

   always @(posedge i_clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         mem[8'h10] <= 16'hBEEF;
         mem[8'h12] <= 16'h5A5A;
         mem[8'h14] <= 16'h1111;
         mem[8'h16] <= 16'h2222;
         mem[8'h30] <= 16'h3333;
         mem[8'h40] <= 16'h4444;
      end else if (o_mem_wen) begin
         mem[o_mem_addr[7:0]] <= o_mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act !== exp) $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      else n_pass = n_pass + 1;
   endtask

   task automatic miss(input string name);
      n_total = n_total + 1;
      $display("FAIL %s: rvalid seen with no outstanding read (cycle %0d)", name, cyc);
   endtask

   task automatic push_cpu(input logic [15:0] d);
      cpu_q.push_back('{data: d, cyc: cyc + 1});
      $display("cyc %0d: cpu read issued, expect %h", cyc, d);
   endtask

   task automatic push_dbg(input logic [15:0] d);
      dbg_q.push_back('{data: d, cyc: cyc + 1});
      $display("cyc %0d: dbg read issued, expect %h", cyc, d);
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                        input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                        input logic dl);
      @(posedge i_clk);
      #1;
      i_cpu_req = cr; i_cpu_wen = cw; i_cpu_addr = ca; i_cpu_wdata = cd;
      i_dbg_req = dr; i_dbg_wen = dw; i_dbg_addr = da; i_dbg_wdata = dd;
      i_dbg_lock = dl;
      @(negedge i_clk);
   endtask

   task automatic idle();
      drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
   endtask

   // Scoreboard monitor: every rvalid must match the oldest outstanding read.
   always @(negedge i_clk) begin
      if (o_cpu_rvalid) begin
         if (cpu_q.size() == 0) miss("cpu_rvalid_unexpected");
         else begin
            mon_e = cpu_q.pop_front();
            chk("cpu_rdata", {16'h0, o_cpu_rdata}, {16'h0, mon_e.data});
            chk("cpu_rvalid_cycle", cyc, mon_e.cyc);
            $display("cyc %0d: cpu rvalid data %h", cyc, o_cpu_rdata);
         end
      end
      if (o_dbg_rvalid) begin
         if (dbg_q.size() == 0) miss("dbg_rvalid_unexpected");
         else begin
            mon_e = dbg_q.pop_front();
            chk("dbg_rdata", {16'h0, o_dbg_rdata}, {16'h0, mon_e.data});
            chk("dbg_rvalid_cycle", cyc, mon_e.cyc);
            $display("cyc %0d: dbg rvalid data %h", cyc, o_dbg_rdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0; preload = 1'b1;
      i_cpu_req = 0; i_cpu_wen = 0; i_cpu_addr = 0; i_cpu_wdata = 0;
      i_dbg_req = 0; i_dbg_wen = 0; i_dbg_addr = 0; i_dbg_wdata = 0; i_dbg_lock = 0;

      // Reset state
      @(negedge i_clk);
      chk("rst_cpu_rvalid", o_cpu_rvalid, 0);
      chk("rst_dbg_rvalid", o_dbg_rvalid, 0);
      chk("rst_cpu_rdata", o_cpu_rdata, 0);
      chk("rst_dbg_rdata", o_dbg_rdata, 0);
      chk("rst_locked", o_locked, 0);
      // Requests during reset: no grants, no write
      drive(1, 1, 16'h0004, 16'h00FF, 1, 1, 16'h0006, 16'h00FF, 0);
      chk("rst_cpu_gnt", o_cpu_gnt, 0);
      chk("rst_dbg_gnt", o_dbg_gnt, 0);
      chk("rst_mem_wen", o_mem_wen, 0);
      chk("rst_cpu_stall", o_cpu_stall, 1);
      i_cpu_req = 0; i_dbg_req = 0; i_cpu_wen = 0; i_dbg_wen = 0;
      i_rst_n = 1'b1; preload = 1'b0;
      $display("cyc %0d: reset released", cyc);

      // Tie after reset: CPU first, then alternation
      drive(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0012, 16'h0, 0);
      chk("tie1_cpu_gnt", o_cpu_gnt, 1);
      chk("tie1_dbg_gnt", o_dbg_gnt, 0);
      chk("tie1_cpu_stall", o_cpu_stall, 0);
      chk("tie1_mem_addr", o_mem_addr, 16'h0010);
      push_cpu(16'hBEEF);
      drive(1, 0, 16'h0014, 16'h0, 1, 0, 16'h0012, 16'h0, 0);
      chk("tie2_dbg_gnt", o_dbg_gnt, 1);
      chk("tie2_cpu_stall", o_cpu_stall, 1);
      chk("tie2_mem_addr", o_mem_addr, 16'h0012);
      push_dbg(16'h5A5A);
      drive(1, 0, 16'h0014, 16'h0, 1, 0, 16'h0016, 16'h0, 0);
      chk("tie3_cpu_gnt", o_cpu_gnt, 1);
      chk("tie3_dbg_gnt", o_dbg_gnt, 0);
      push_cpu(16'h1111);
      drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0016, 16'h0, 0);
      chk("tie4_dbg_gnt", o_dbg_gnt, 1);
      push_dbg(16'h2222);

      // Idle bus
      idle();
      chk("idle_cpu_gnt", o_cpu_gnt, 0);
      chk("idle_dbg_gnt", o_dbg_gnt, 0);
      chk("idle_mem_wen", o_mem_wen, 0);
      chk("idle_mem_addr", o_mem_addr, 0);
      chk("idle_mem_wdata", o_mem_wdata, 0);

      // CPU read alone
      drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0);
      chk("solo_cpu_gnt", o_cpu_gnt, 1);
      chk("solo_mem_addr", o_mem_addr, 16'h0010);
      push_cpu(16'hBEEF);
      idle();

      // CPU write then back-to-back read of the same word
      drive(1, 1, 16'h0004, 16'h00AA, 0, 0, 16'h0, 16'h0, 0);
      chk("wr_cpu_gnt", o_cpu_gnt, 1);
      chk("wr_mem_wen", o_mem_wen, 1);
      chk("wr_mem_wdata", o_mem_wdata, 16'h00AA);
      drive(1, 0, 16'h0004, 16'h0, 0, 0, 16'h0, 16'h0, 0);
      chk("rd_cpu_gnt", o_cpu_gnt, 1);
      chk("rd_mem_wen", o_mem_wen, 0);
      push_cpu(16'h00AA);

      // Debug lock: four writes, CPU stalled throughout
      drive(1, 0, 16'h0030, 16'h0, 1, 1, 16'h0020, 16'h1234, 1);
      chk("lk0_dbg_gnt", o_dbg_gnt, 1);
      chk("lk0_cpu_gnt", o_cpu_gnt, 0);
      chk("lk0_locked", o_locked, 0);
      chk("lk0_mem_addr", o_mem_addr, 16'h0020);
      chk("lk0_mem_wdata", o_mem_wdata, 16'h1234);
      for (int k = 1; k < 4; k++) begin
         drive(1, 0, 16'h0030, 16'h0, 1, 1, 16'h0020, 16'h1234, 1);
         chk("lk_locked", o_locked, 1);
         chk("lk_dbg_gnt", o_dbg_gnt, 1);
         chk("lk_cpu_stall", o_cpu_stall, 1);
      end
      drive(1, 0, 16'h0030, 16'h0, 0, 0, 16'h0, 16'h0, 0);
      chk("unlk_locked_still", o_locked, 1);
      chk("unlk_cpu_gnt_blocked", o_cpu_gnt, 0);
      drive(1, 0, 16'h0030, 16'h0, 0, 0, 16'h0, 16'h0, 0);
      chk("unlk_locked", o_locked, 0);
      chk("unlk_cpu_gnt", o_cpu_gnt, 1);
      push_cpu(16'h3333);
      drive(1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0, 0);
      chk("rb_cpu_gnt", o_cpu_gnt, 1);
      push_cpu(16'h1234);
      idle();

      // Reset in the middle of a granted, locked debug read
      drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0040, 16'h0, 1);
      chk("ab0_dbg_gnt", o_dbg_gnt, 1);
      push_dbg(16'h4444);
      drive(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0040, 16'h0, 1);
      chk("ab1_locked", o_locked, 1);
      chk("ab1_dbg_gnt", o_dbg_gnt, 1);
      #2;
      i_rst_n = 1'b0; i_dbg_req = 0; i_dbg_lock = 0;
      $display("cyc %0d: reset asserted mid-access", cyc);
      #1;
      chk("ab_rst_dbg_gnt", o_dbg_gnt, 0);
      chk("ab_rst_cpu_gnt", o_cpu_gnt, 0);
      chk("ab_rst_locked", o_locked, 0);
      chk("ab_rst_dbg_rdata", o_dbg_rdata, 0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      chk("ab_rel_cpu_gnt", o_cpu_gnt, 1);
      chk("ab_rel_locked", o_locked, 0);
      chk("ab_rel_dbg_rvalid", o_dbg_rvalid, 0);
      push_cpu(16'hBEEF);
      idle();
      idle();

      chk("cpu_q_drained", cpu_q.size(), 0);
      chk("dbg_q_drained", dbg_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
